// File: rtl/dw_data_handoff_mc.sv
// Multi-channel data handoff: per-channel pending queues drained round-robin
// into a single ready/valid output register with drop and done reporting.
module dw_data_handoff_mc #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned PEND_DEPTH = 2,
    parameter int unsigned DONE_MODE  = 0,
    parameter int unsigned CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init,
    input  logic [CHANNELS-1:0]       send,
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic                      ready_in,
    output logic [CHANNELS-1:0]       empty,
    output logic [CHANNELS-1:0]       full,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       drop,
    output logic                      data_avail,
    output logic [WIDTH-1:0]          data_out,
    output logic [CW-1:0]             chan_out
);

    localparam int unsigned PW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int unsigned NW = $clog2(PEND_DEPTH + 1);

    logic [WIDTH-1:0]    mem     [CHANNELS][PEND_DEPTH];
    logic [PW-1:0]       rd_ptr  [CHANNELS];
    logic [PW-1:0]       wr_ptr  [CHANNELS];
    logic [NW-1:0]       cnt     [CHANNELS];
    logic [NW-1:0]       cnt_nxt [CHANNELS];
    logic [CW-1:0]       last_grant;
    logic [CW-1:0]       cand;
    logic [CW-1:0]       grant_idx;
    logic                grant_found;
    logic                load_en;
    logic                handshake;
    logic [CHANNELS-1:0] enq;
    logic [CHANNELS-1:0] deq;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(PEND_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin grant from registered counts, plus per-channel enqueue/dequeue decode.
    always_comb begin
        handshake   = data_avail & ready_in;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = CW'((32'(last_grant) + i) % CHANNELS);
            if (!grant_found && (cnt[cand] != '0)) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        load_en = (!data_avail || ready_in) && grant_found;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            enq[c]     = send[c] & ~full[c];
            deq[c]     = load_en && (grant_idx == CW'(c));
            cnt_nxt[c] = cnt[c] + NW'(enq[c]) - NW'(deq[c]);
        end
    end

    // Queue state, output register and status/pulse registers.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
            last_grant <= CW'(CHANNELS - 1);
            empty      <= '1;
            full       <= '0;
            done       <= '0;
            drop       <= '0;
            data_avail <= 1'b0;
            data_out   <= '0;
            chan_out   <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (enq[c]) begin
                    mem[c][wr_ptr[c]] <= data[c*WIDTH +: WIDTH];
                    wr_ptr[c]         <= ptr_inc(wr_ptr[c]);
                end
                if (deq[c]) begin
                    rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                end
                cnt[c]   <= cnt_nxt[c];
                empty[c] <= (cnt_nxt[c] == '0);
                full[c]  <= (cnt_nxt[c] == NW'(PEND_DEPTH));
            end
            drop <= send & full;
            if (DONE_MODE != 0) begin
                done <= enq;
            end else begin
                done <= handshake ? (CHANNELS'(1) << chan_out) : '0;
            end
            if (load_en) begin
                data_avail <= 1'b1;
                data_out   <= mem[grant_idx][rd_ptr[grant_idx]];
                chan_out   <= grant_idx;
                last_grant <= grant_idx;
            end else if (handshake) begin
                data_avail <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dw_data_handoff_mc.sv
// Bench for dw_data_handoff_mc: two instances (depth 2 / done on take, depth 3 /
// done on enqueue) share stimulus and are compared every cycle to a queue model.
module tb_dw_data_handoff_mc;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            init;
    logic [CH-1:0]   send;
    logic [CH*W-1:0] data;
    logic            ready_in;

    logic [CH-1:0] empty_o [NI];
    logic [CH-1:0] full_o  [NI];
    logic [CH-1:0] done_o  [NI];
    logic [CH-1:0] drop_o  [NI];
    logic          avail_o [NI];
    logic [W-1:0]  dout_o  [NI];
    logic [1:0]    chan_o  [NI];

    dw_data_handoff_mc #(.WIDTH(W), .CHANNELS(CH), .PEND_DEPTH(2), .DONE_MODE(0)) u_a (
        .clk(clk), .rst(rst), .init(init), .send(send), .data(data), .ready_in(ready_in),
        .empty(empty_o[0]), .full(full_o[0]), .done(done_o[0]), .drop(drop_o[0]),
        .data_avail(avail_o[0]), .data_out(dout_o[0]), .chan_out(chan_o[0])
    );

    dw_data_handoff_mc #(.WIDTH(W), .CHANNELS(CH), .PEND_DEPTH(3), .DONE_MODE(1)) u_b (
        .clk(clk), .rst(rst), .init(init), .send(send), .data(data), .ready_in(ready_in),
        .empty(empty_o[1]), .full(full_o[1]), .done(done_o[1]), .drop(drop_o[1]),
        .data_avail(avail_o[1]), .data_out(dout_o[1]), .chan_out(chan_o[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one word queue per channel, an output slot and a grant pointer.
    logic [W-1:0]  mq [NI][CH][$];
    logic          m_avail [NI];
    logic [W-1:0]  m_dout  [NI];
    int            m_chan  [NI];
    logic [CH-1:0] m_done  [NI];
    logic [CH-1:0] m_drop  [NI];
    int            m_last  [NI];
    int            depth   [NI] = '{2, 3};
    int            mode    [NI] = '{0, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int n);
        logic [CH-1:0] fullp;
        bit            hs;
        int            win;
        int            k;
        if (rst || init) begin
            for (int c = 0; c < CH; c++) mq[n][c].delete();
            m_avail[n] = 1'b0;
            m_dout[n]  = '0;
            m_chan[n]  = 0;
            m_done[n]  = '0;
            m_drop[n]  = '0;
            m_last[n]  = CH - 1;
            return;
        end
        for (int c = 0; c < CH; c++) fullp[c] = (mq[n][c].size() == depth[n]);
        hs  = m_avail[n] && ready_in;
        win = -1;
        if (!m_avail[n] || ready_in) begin
            for (int i = 1; i <= CH; i++) begin
                k = (m_last[n] + i) % CH;
                if (win < 0 && mq[n][k].size() > 0) win = k;
            end
        end
        if (mode[n] == 0) m_done[n] = hs ? (CH'(1) << m_chan[n]) : '0;
        else              m_done[n] = send & ~fullp;
        m_drop[n] = send & fullp;
        if (win >= 0) begin
            m_dout[n]  = mq[n][win].pop_front();
            m_chan[n]  = win;
            m_last[n]  = win;
            m_avail[n] = 1'b1;
        end else if (hs) begin
            m_avail[n] = 1'b0;
        end
        for (int c = 0; c < CH; c++)
            if (send[c] && !fullp[c]) mq[n][c].push_back(data[c*W +: W]);
    endtask

    always @(posedge clk) begin
        for (int n = 0; n < NI; n++) model_step(n);
    end

    task automatic check_all();
        logic [CH-1:0] e;
        logic [CH-1:0] f;
        for (int n = 0; n < NI; n++) begin
            for (int c = 0; c < CH; c++) begin
                e[c] = (mq[n][c].size() == 0);
                f[c] = (mq[n][c].size() == depth[n]);
            end
            chk($sformatf("avail%0d", n), 64'(avail_o[n]), 64'(m_avail[n]));
            chk($sformatf("dout%0d", n),  64'(dout_o[n]),  64'(m_dout[n]));
            chk($sformatf("chan%0d", n),  64'(chan_o[n]),  64'(m_chan[n]));
            chk($sformatf("done%0d", n),  64'(done_o[n]),  64'(m_done[n]));
            chk($sformatf("drop%0d", n),  64'(drop_o[n]),  64'(m_drop[n]));
            chk($sformatf("empty%0d", n), 64'(empty_o[n]), 64'(e));
            chk($sformatf("full%0d", n),  64'(full_o[n]),  64'(f));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic post(input int c, input logic [W-1:0] v);
        send       = '0;
        send[c]    = 1'b1;
        data       = '0;
        data[c*W +: W] = v;
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; send = '0; data = '0; ready_in = 1'b1;
        for (int n = 0; n < NI; n++) begin
            m_avail[n] = 1'b0; m_dout[n] = '0; m_chan[n] = 0;
            m_done[n] = '0; m_drop[n] = '0; m_last[n] = CH - 1;
        end

        // reset and first handoff
        cycle(); cycle();
        chk("rst_empty", 64'(empty_o[0]), 64'hF);
        chk("rst_avail", 64'(avail_o[0]), 64'h0);
        rst = 1'b0;
        post(2, 8'hA5);
        cycle();
        send = '0;
        cycle();
        chk("first_avail", 64'(avail_o[0]), 64'h1);
        chk("first_data",  64'(dout_o[0]),  64'hA5);
        chk("first_chan",  64'(chan_o[0]),  64'h2);
        cycle();
        chk("first_done",  64'(done_o[0]),  64'h4);
        chk("first_empty", 64'(empty_o[0]), 64'hF);
        cycle();

        // full and drop on channel 0 with the consumer stalled
        ready_in = 1'b0;
        post(0, 8'h11); cycle();
        post(0, 8'h22); cycle();
        post(0, 8'h33); cycle();
        chk("fill_full", 64'(full_o[0]), 64'h1);
        chk("fill_out",  64'(dout_o[0]), 64'h11);
        post(0, 8'h44); cycle();
        chk("drop0", 64'(drop_o[0]), 64'h1);
        send = '0;
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // round robin with uneven fill, then backpressure hold
        ready_in = 1'b0;
        for (int r = 0; r < 2; r++) begin
            send = (r == 0) ? 4'hF : 4'h5;
            data = $urandom;
            cycle();
        end
        send = '0;
        for (int i = 0; i < 5; i++) begin
            send = 4'hA; data = $urandom;
            cycle();
        end
        send = '0;
        ready_in = 1'b1;
        for (int i = 0; i < 12; i++) cycle();

        // stream on one channel: send and take each cycle across pointer wrap
        for (int i = 0; i < 10; i++) begin
            post(1, 8'(8'h60 + i));
            cycle();
        end
        send = '0;
        for (int i = 0; i < 4; i++) cycle();

        // init with words queued and one held in the output register
        ready_in = 1'b0;
        post(3, 8'hC1); cycle();
        post(3, 8'hC2); cycle();
        post(3, 8'hC3); cycle();
        send = '0;
        init = 1'b1;
        cycle();
        init = 1'b0;
        chk("init_avail", 64'(avail_o[0]), 64'h0);
        chk("init_empty", 64'(empty_o[0]), 64'hF);
        chk("init_pulse", 64'({done_o[0], drop_o[0]}), 64'h0);
        send = 4'b1001; data = 32'h7700_0033;
        cycle();
        send = '0; ready_in = 1'b1;
        cycle();
        chk("init_grant", 64'(chan_o[0]), 64'h0);
        chk("init_gdata", 64'(dout_o[0]), 64'h33);

        // randomized traffic with occasional soft clear
        for (int i = 0; i < 1500; i++) begin
            send     = 4'($urandom) & 4'($urandom);
            data     = $urandom;
            ready_in = ($urandom_range(0, 3) != 0);
            init     = ($urandom_range(0, 63) == 0);
            cycle();
        end
        init = 1'b0; send = '0; ready_in = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dw_data_handoff_mc.md
# dw_data_handoff_mc

Single-clock, multi-channel data handoff block. It is the parametrised successor to our single-channel pending-mode data synchroniser. Each of `CHANNELS` producers posts words into its own pending queue of `PEND_DEPTH` entries. A round-robin arbiter then drains the queues into one output register, which the consumer accepts with a ready/valid handshake. The block sits between several local request sources and one shared sink. It adds three things the single-channel block lacks: consumer backpressure, per-channel drop reporting, and selectable done semantics.

## Interface
Parameters:
- `WIDTH`, 8: data word width, 1..256.
- `CHANNELS`, 4: number of producer channels, 1..16.
- `PEND_DEPTH`, 2: pending entries per channel, 1..8. Need not be a power of two.
- `DONE_MODE`, 0: 0 = `done` pulses when the consumer takes the word; 1 = `done` pulses when the word is enqueued.
- `CW` (derived): max(1, clog2(`CHANNELS`)).

Ports:
- `clk`  in  1: the single clock. All logic is rising-edge.
- `rst`  in  1: reset, synchronous, active-high. Has priority over every other input.
- `init`  in  1: synchronous soft clear, active-high. Same effect as `rst`.
- `send`  in  `CHANNELS`: per-channel request to post one word, one bit per channel.
- `data`  in  `CHANNELS*WIDTH`: posted words. Channel c occupies bits [c*WIDTH +: WIDTH].
- `ready_in`  in  1: consumer accepts the output word this cycle.
- `empty`  out  `CHANNELS`: channel queue count == 0.
- `full`  out  `CHANNELS`: channel queue count == `PEND_DEPTH`.
- `done`  out  `CHANNELS`: one-cycle completion pulse per channel.
- `drop`  out  `CHANNELS`: one-cycle pulse when a `send` is rejected.
- `data_avail`  out  1: output register valid.
- `data_out`  out  `WIDTH`: output word.
- `chan_out`  out  `CW`: source channel of `data_out`.

## Operation
- **Per-channel queue:** circular FIFO with read pointer, write pointer and count. Pointers wrap at `PEND_DEPTH-1` to 0 explicitly, with no power-of-two masking.
- **Enqueue:** `send[c]`=1 with `full[c]`=0 writes `data[c]` and increments the count.
- **Reject:** `send[c]`=1 with `full[c]`=1 discards the word, leaves queue state unchanged and pulses `drop[c]` next cycle.
- **Full uses the registered count.** A dequeue in the same cycle does not free the slot for that cycle's `send`.
- **Simultaneous send and dequeue on a non-full channel:** the write and the read both occur, and the count is unchanged.
- **Output register load condition:** loads when (`data_avail`=0) or (`data_avail`=1 and `ready_in`=1), and at least one queue is non-empty.
- **Arbitration:** round-robin over non-empty queues, using registered counts only.
  - The search starts at `last_grant+1` modulo `CHANNELS`.
  - The winner's head word goes to `data_out` and its index to `chan_out`. Its count decrements and `last_grant` updates.
- **Output hold:**
  - `data_avail`=1 and `ready_in`=0: `data_out` and `chan_out` hold stable.
  - `data_avail`=1, `ready_in`=1 and no queue pending: `data_avail` drops to 0. `data_out` and `chan_out` keep their last values.
  - `ready_in` while `data_avail`=0 is ignored.
- **`done`:**
  - `DONE_MODE`=0: `done[chan_out]` pulses the cycle after the handshake (`data_avail`&`ready_in`).
  - `DONE_MODE`=1: `done[c]` pulses the cycle after a successful enqueue.
  - Multiple bits may pulse together in mode 1.
- **`rst` or `init`:** clears all queues, output and pulse registers. `last_grant` is set to `CHANNELS-1`, so channel 0 has first priority. Words in flight are lost with no `done` and no `drop`.

## Timing
- Reset values: `empty` all ones; `full`, `done`, `drop` all zero; `data_avail`=0; `data_out`=0; `chan_out`=0.
- `empty`, `full`, `done`, `drop`, `data_avail`, `data_out` and `chan_out` are all registered. There is no combinational input-to-output path.
- **Minimum latency:** `send` sampled at edge k → count updated after k → output loaded at edge k+1. `data_avail` is visible 1 cycle after the send edge, i.e. 2 cycles from driving `send`.
- **Sustained throughput:** 1 word/cycle with `ready_in` held high and any queue non-empty.
- `drop` and `done` (mode 1) appear in the cycle after the sampling edge.
- `done` (mode 0) appears in the cycle after the handshake edge.
- `rst`/`init` asserted at edge k: all outputs are at reset values after edge k. A `send` sampled at edge k is ignored.

## Test plan
- **Reset and first handoff:** CHANNELS=4, PEND_DEPTH=2. `rst` for 2 cycles, then `send[2]`=1 with `data`=0xA5 for one cycle, `ready_in`=1. Required: `data_avail`=1, `data_out`=0xA5, `chan_out`=2 one cycle after the send edge; `done[2]` pulses the following cycle (mode 0); `empty` returns to 4'b1111.
- **Full and drop:** `ready_in`=0. Three sends on channel 0 (0x11, 0x22, 0x33). Required:
  - 0x11 moves to the output register.
  - 0x22 and 0x33 fill the queue, so `full[0]`=1.
  - A 4th send 0x44 pulses `drop[0]`.
  - With `ready_in`=1, the consumer then sees 0x11, 0x22, 0x33 in order, and 0x44 never appears.
- **Round-robin fairness:** all four channels are non-empty and `ready_in`=1. Required: `chan_out` sequence 0,1,2,3,0… A channel that becomes empty is skipped without a bubble.
- **Backpressure hold:** with `data_avail`=1, `ready_in` is held low for 5 cycles. Required: `data_out` and `chan_out` stay constant, no `done` pulses, and queues fill up to `full`.
- **Wrap and simultaneous events, PEND_DEPTH=3:** 10 words are streamed on one channel, with a send and a dequeue in the same cycle while count=1. Required: the count stays at 1, the data order is preserved across pointer wrap, and there are no drops.
- **Init mid-operation:** `init` pulses with 2 words queued and 1 in the output register. Required: next cycle `data_avail`=0 and `empty` is all ones, no `done`/`drop` pulses, and the next grant goes to channel 0.
